// File: rtl/mmio_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_ctrl
// Memory-mapped I/O controller for the pipelined 16-bit core. It sits on the
// data-memory port and claims an 8-word window at BASE (word stride 2 bytes).
//
// Register map (byte offset from BASE, ADDR[0] ignored):
//   0 KEYS  (R)    debounced KEY level, raw (active-low) polarity
//   2 SWS   (R)    debounced SW
//   4 KEDGE (R/W1C) bit i: debounced KEY[i] press seen; bit DBITS-1: timer wrap
//   6 TCNT  (R/W)  timer count
//   8 HEX   (R/W)  seven-segment value
//  10 LEDR  (R/W)  red LEDs
//  12 LEDG  (R/W)  green LEDs
//  14 TLIM  (R/W)  timer limit (0 = free-running)
//
// Ports:
//   i_clk     system clock
//   i_resetn  synchronous reset, active low
//   i_addr    byte address from core
//   i_re      read strobe
//   i_we      write strobe
//   i_wdata   write data
//   o_rdata   registered read data (1-cycle latency, holds otherwise)
//   o_hit     combinational: i_addr within [BASE, BASE+15]
//   i_key     raw push buttons, active low
//   i_sw      raw switches
//   o_hexout  value for the four seven-segment digits
//   o_ledr    red LEDs
//   o_ledg    green LEDs
// -----------------------------------------------------------------------------
module mmio_ctrl #(
   parameter int               DBITS   = 16,
   parameter logic [DBITS-1:0] BASE    = 16'hFFF0,
   parameter int               NKEYS   = 4,
   parameter int               NSW     = 10,
   parameter int               NLEDR   = 10,
   parameter int               NLEDG   = 8,
   parameter int               DEBCYC  = 65535,
   parameter int               TICKDIV = 50000
) (
   input  logic              i_clk,
   input  logic              i_resetn,
   input  logic [DBITS-1:0]  i_addr,
   input  logic              i_re,
   input  logic              i_we,
   input  logic [DBITS-1:0]  i_wdata,
   output logic [DBITS-1:0]  o_rdata,
   output logic              o_hit,
   input  logic [NKEYS-1:0]  i_key,
   input  logic [NSW-1:0]    i_sw,
   output logic [DBITS-1:0]  o_hexout,
   output logic [NLEDR-1:0]  o_ledr,
   output logic [NLEDG-1:0]  o_ledg
);

   // KEY and SW share one synchroniser/debounce path: KEYs in the low bits.
   localparam int NIN = NKEYS + NSW;
   localparam int CW  = (DEBCYC  > 1) ? $clog2(DEBCYC)  : 1;
   localparam int PW  = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
   // Released keys read 1, switches start at 0.
   localparam logic [NIN-1:0] IN_RST   = {{NSW{1'b0}}, {NKEYS{1'b1}}};
   localparam logic [CW-1:0]  DEB_LAST = CW'(DEBCYC - 1);
   localparam logic [PW-1:0]  PRE_LAST = PW'(TICKDIV - 1);

   typedef enum logic [2:0] {
      OFF_KEYS  = 3'd0,
      OFF_SWS   = 3'd1,
      OFF_KEDGE = 3'd2,
      OFF_TCNT  = 3'd3,
      OFF_HEX   = 3'd4,
      OFF_LEDR  = 3'd5,
      OFF_LEDG  = 3'd6,
      OFF_TLIM  = 3'd7
   } off_t;

   logic [NIN-1:0]   r_sync1;
   logic [NIN-1:0]   r_sync2;
   logic [NIN-1:0]   r_deb;
   logic [CW-1:0]    r_dcnt [NIN];
   logic [PW-1:0]    r_pre;
   logic [DBITS-1:0] r_tcnt;
   logic [DBITS-1:0] r_tlim;
   logic [DBITS-1:0] r_kedge;
   logic [DBITS-1:0] r_hex;
   logic [NLEDR-1:0] r_ledr;
   logic [NLEDG-1:0] r_ledg;
   logic [DBITS-1:0] r_rdata;

   logic             w_hit;
   logic             w_wr;
   logic             w_rd;
   off_t             w_off;
   logic [NIN-1:0]   w_deb_upd;
   logic [NKEYS-1:0] w_key_fall;
   logic             w_tick;
   logic             w_wrap;
   logic [DBITS-1:0] w_tcnt_nxt;
   logic [DBITS-1:0] w_kedge_set;
   logic [DBITS-1:0] w_kedge_clr;
   logic [DBITS-1:0] w_keys;
   logic [DBITS-1:0] w_sws;
   logic [DBITS-1:0] w_ledr_x;
   logic [DBITS-1:0] w_ledg_x;
   logic [DBITS-1:0] w_rd_val;

   always_comb begin
      // Full-range compare so the window test also holds for odd addresses.
      w_hit = (i_addr >= BASE) && (i_addr <= (BASE + DBITS'(15)));
      w_off = off_t'(i_addr[3:1]);
      w_wr  = i_we & w_hit;
      w_rd  = i_re & w_hit;

      // A debounced bit flips when its input has differed for DEBCYC
      // consecutive cycles, i.e. the counter sits at its last value.
      w_deb_upd = '0;
      for (int i = 0; i < NIN; i++) begin
         w_deb_upd[i] = (r_sync2[i] != r_deb[i]) && (r_dcnt[i] == DEB_LAST);
      end
      // Press = debounced 1->0; a flipping bit that is currently 1 is a press.
      w_key_fall = w_deb_upd[NKEYS-1:0] & r_deb[NKEYS-1:0];

      w_tick     = (r_pre == PRE_LAST);
      w_wrap     = 1'b0;
      w_tcnt_nxt = r_tcnt;
      if (w_wr && (w_off == OFF_TCNT)) begin
         w_tcnt_nxt = i_wdata;            // CPU write beats a coincident tick
      end else if (w_tick) begin
         if ((r_tlim != '0) && (r_tcnt == r_tlim)) begin
            w_tcnt_nxt = '0;
            w_wrap     = 1'b1;
         end else begin
            w_tcnt_nxt = r_tcnt + DBITS'(1);
         end
      end

      w_kedge_set              = '0;
      w_kedge_set[NKEYS-1:0]   = w_key_fall;
      w_kedge_set[DBITS-1]     = w_wrap;
      w_kedge_clr              = (w_wr && (w_off == OFF_KEDGE)) ? i_wdata : '0;

      w_keys             = '0;
      w_keys[NKEYS-1:0]  = r_deb[NKEYS-1:0];
      w_sws              = '0;
      w_sws[NSW-1:0]     = r_deb[NIN-1:NKEYS];
      w_ledr_x           = '0;
      w_ledr_x[NLEDR-1:0] = r_ledr;
      w_ledg_x           = '0;
      w_ledg_x[NLEDG-1:0] = r_ledg;

      // Read mux uses current register contents, so RE+WE returns old data.
      case (w_off)
         OFF_KEYS:  w_rd_val = w_keys;
         OFF_SWS:   w_rd_val = w_sws;
         OFF_KEDGE: w_rd_val = r_kedge;
         OFF_TCNT:  w_rd_val = r_tcnt;
         OFF_HEX:   w_rd_val = r_hex;
         OFF_LEDR:  w_rd_val = w_ledr_x;
         OFF_LEDG:  w_rd_val = w_ledg_x;
         default:   w_rd_val = r_tlim;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_sync1 <= IN_RST;
         r_sync2 <= IN_RST;
         r_deb   <= IN_RST;
         for (int i = 0; i < NIN; i++) begin
            r_dcnt[i] <= '0;
         end
         r_pre   <= '0;
         r_tcnt  <= '0;
         r_tlim  <= '0;
         r_kedge <= '0;
         r_hex   <= '0;
         r_ledr  <= '0;
         r_ledg  <= '0;
         r_rdata <= '0;
      end else begin
         r_sync1 <= {i_sw, i_key};
         r_sync2 <= r_sync1;
         for (int i = 0; i < NIN; i++) begin
            if ((r_sync2[i] == r_deb[i]) || w_deb_upd[i]) begin
               r_dcnt[i] <= '0;
            end else begin
               r_dcnt[i] <= r_dcnt[i] + CW'(1);
            end
         end
         r_deb <= r_deb ^ w_deb_upd;

         // Prescaler free-runs; a TCNT write does not re-phase it.
         r_pre  <= w_tick ? '0 : r_pre + PW'(1);
         r_tcnt <= w_tcnt_nxt;

         // Set terms are OR-ed after the clear so a same-cycle set survives.
         r_kedge <= (r_kedge & ~w_kedge_clr) | w_kedge_set;

         if (w_wr) begin
            case (w_off)
               OFF_HEX:  r_hex  <= i_wdata;
               OFF_LEDR: r_ledr <= i_wdata[NLEDR-1:0];
               OFF_LEDG: r_ledg <= i_wdata[NLEDG-1:0];
               OFF_TLIM: r_tlim <= i_wdata;
               default:  ;
            endcase
         end

         if (w_rd) begin
            r_rdata <= w_rd_val;
         end
      end
   end

   assign o_rdata  = r_rdata;
   assign o_hit    = w_hit;
   assign o_hexout = r_hex;
   assign o_ledr   = r_ledr;
   assign o_ledg   = r_ledg;

endmodule

// File: doc/mmio_ctrl.md
Name: mmio_ctrl

Overview:
- Parametrised memory-mapped I/O controller for the pipelined 16-bit core; it replaces the inline KEY/SW/HEX/LEDR/LEDG decode in the core top level.
- Sits on the core's data-memory port beside the memory array. The core asserts RE/WE with an address; the block claims addresses in an 8-word window at BASE.
- New over the inline version:
  - synchronised, debounced KEY and SW inputs;
  - sticky key-press capture register with write-1-to-clear;
  - programmable tick timer with wrap flag;
  - registered read data.

Parameters:
DBITS, 16, data/address width
BASE, 16'hFFF0, byte address of the window (8 words, word stride 2; BASE[3:0] must be 0)
NKEYS, 4, number of KEY inputs (≤ DBITS-1)
NSW, 10, number of switches (≤ DBITS)
NLEDR, 10, red LED width (≤ DBITS)
NLEDG, 8, green LED width (≤ DBITS)
DEBCYC, 65535, consecutive stable cycles before a debounced input changes (≥ 1)
TICKDIV, 50000, CLK cycles per timer tick (≥ 1)

Ports:
CLK  in  1  system clock
RESETN  in  1  synchronous reset, active low
ADDR  in  DBITS  byte address from core
RE  in  1  read strobe
WE  in  1  write strobe
WDATA  in  DBITS  write data
RDATA  out  DBITS  registered read data
HIT  out  1  combinational: ADDR within [BASE, BASE+15]
KEY  in  NKEYS  raw push buttons, active low
SW  in  NSW  raw switches
HEXOUT  out  DBITS  value for the four seven-seg digits
LEDR  out  NLEDR  red LEDs
LEDG  out  NLEDG  green LEDs

Behaviour:
- One clock (CLK). All state updates on posedge CLK. RESETN is sampled synchronously and is active low; it overrides every other input in the same cycle.
- Register map (offset from BASE; ADDR[0] ignored):
  - 0 KEYS (R): debounced KEY level, raw polarity, zero-extended.
  - 2 SWS (R): debounced SW, zero-extended.
  - 4 KEDGE (R/W1C): bit i set on a debounced KEY[i] 1→0 transition; bit DBITS-1 = timer wrap flag. A write clears the bits where WDATA=1.
  - 6 TCNT (R/W): timer count.
  - 8 HEX (R/W), 10 LEDR (R/W), 12 LEDG (R/W): writes take the low bits of WDATA; reads return the zero-extended register.
  - 14 TLIM (R/W): timer limit.
  - Writes to read-only offsets are ignored.
- Input path: 2-flop synchroniser per KEY/SW bit, then debounce. Each bit has its own counter. The counter resets to 0 whenever the synced input equals the debounced value. The debounced value takes the synced value on the cycle the counter reaches DEBCYC-1 with the input still differing. Minimum debounced-change latency after a clean input step is 2+DEBCYC cycles.
- Edge capture: a set event and a W1C clear of the same bit in the same cycle → bit ends set (set wins).
- Timer:
  - Prescaler counts 0..TICKDIV-1 continuously.
  - On prescaler wrap: if TLIM==0, TCNT increments modulo 2^DBITS. Otherwise, when TCNT==TLIM, TCNT←0 and the wrap flag is set; else TCNT increments.
  - CPU write to TCNT in the same cycle as a tick: the write wins and the prescaler resets to 0.
  - Write to TLIM does not disturb TCNT. If TCNT>TLIM, TCNT counts up through 2^DBITS-1 to 0 before matching.
- Read: when RE && HIT at edge n, RDATA holds the addressed value sampled at edge n, visible after edge n. Latency is 1 cycle. RDATA otherwise holds its last value.
- RE and WE to the same register in the same cycle: RDATA returns the pre-write value.
- When HIT=0, WE/RE have no effect.
- Reset values:
  - RDATA 0, HEXOUT 0, LEDR 0, LEDG 0, KEDGE 0, TCNT 0, TLIM 0, prescaler 0.
  - Debounced KEY all 1 (released); synchronisers all 1 for KEY, 0 for SW; debounced SW 0; debounce counters 0.
- Reset mid-debounce discards the partial count. KEY held low through reset produces one KEDGE set DEBCYC+2 cycles after release of reset, not at reset.

Test Plan:
- Reset, then read offsets 0..14 with KEY=4'hF, SW=0 → RDATA F,0,0,0,0,0,0,0 one cycle after each RE; HIT=1 for 0xFFF0..0xFFFF, 0 for 0xFFEE and 0x0000.
- DEBCYC=4: KEY[1] low for 3 cycles then high → no change. Low for 10 cycles → KEYS=0xD after exactly 6 cycles and KEDGE bit1=1. Write KEDGE 0x0002 → bit1=0. Clear in the same cycle as a new edge → bit remains 1.
- Write HEX 0xBEEF, LEDR 0xFFFF, LEDG 0x1234 → HEXOUT=BEEF, LEDR=0x3FF, LEDG=0x34 on the next edge. Readback returns 0xBEEF, 0x03FF, 0x0034. Write 0x5555 to offset 2 → SWS unchanged.
- TICKDIV=3, TLIM=2 → TCNT sequence 0,1,2,0 every 3 cycles; KEDGE bit15 set at the 2→0 wrap. TCNT write of 0x7 coincident with a tick → TCNT=7, next tick 3 cycles later.
- Pulse RESETN low for one cycle mid-count (TCNT=5, LEDR=0x3FF, a debounce half done) → all outputs return to reset values on that edge; the partial debounce does not complete.
- RE+WE same cycle to HEX (old 0x1111, new 0x2222) → RDATA=0x1111, HEXOUT=0x2222.
